lcd114_fill_master: RTL and testbench

- Bus initiator that drives the LCD114 peripheral through the native valid/ready memory interface, taking the CPU's place.
- On a start pulse it runs a hardware sequence: optional boot write, status poll, then CASET/RASET/RAMWR window setup, then a solid-colour pixel burst.
- Offloads rectangle fills from firmware. Sits between a small control-register front end and the LCD peripheral port.

---
 rtl/lcd114_pkg.sv | 45 ++++
 rtl/lcd114_bus_req.sv | 80 ++++++++
 rtl/lcd114_fill_master.sv | 212 +++++++++++++++++++++
 tb/tb_lcd114_fill_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd114_pkg.sv
// Shared constants, FSM state encoding and command-word helper for the LCD114 fill master.
package lcd114_pkg;

    localparam logic [31:0] REG_CMD   = 32'h0000_0000;
    localparam logic [31:0] REG_PIX   = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL  = 32'h0000_0008;
    localparam logic [15:0] DATA_FLAG = 16'h0100;
    localparam logic [7:0]  CASET     = 8'h2A;
    localparam logic [7:0]  RASET     = 8'h2B;
    localparam logic [7:0]  RAMWR     = 8'h2C;
    localparam logic [31:0] BOOT_WORD = 32'hFFFF_FFFF;
    localparam int          CMD_WORDS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_BOOT,
        ST_POLL,
        ST_CMD,
        ST_PIX,
        ST_FIN
    } state_t;

    // Window-setup word list: CASET + 4 data bytes, RASET + 4 data bytes, RAMWR.
    function automatic logic [31:0] cmd_word(input logic [3:0] idx, input logic [15:0] xs,
                                             input logic [15:0] xe, input logic [15:0] ys,
                                             input logic [15:0] ye);
        logic [15:0] w;
        case (idx)
            4'd0:    w = {8'h00, CASET};
            4'd1:    w = DATA_FLAG | {8'h00, xs[15:8]};
            4'd2:    w = DATA_FLAG | {8'h00, xs[7:0]};
            4'd3:    w = DATA_FLAG | {8'h00, xe[15:8]};
            4'd4:    w = DATA_FLAG | {8'h00, xe[7:0]};
            4'd5:    w = {8'h00, RASET};
            4'd6:    w = DATA_FLAG | {8'h00, ys[15:8]};
            4'd7:    w = DATA_FLAG | {8'h00, ys[7:0]};
            4'd8:    w = DATA_FLAG | {8'h00, ye[15:8]};
            4'd9:    w = DATA_FLAG | {8'h00, ye[7:0]};
            default: w = {8'h00, RAMWR};
        endcase
        return {16'h0000, w};
    endfunction

endpackage

// File: rtl/lcd114_bus_req.sv
// Single-beat valid/ready request engine with a per-request timeout.
// ack/timeout are combinational so the sequencer can queue the next beat after one idle cycle.
module lcd114_bus_req
    import lcd114_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic        ack,
    output logic        timeout,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic          valid_q, valid_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        timeout = 1'b0;
        if (valid_q) begin
            if (mem_ready) begin
                ack     = 1'b1;
                valid_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                timeout = 1'b1;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (req) begin
            // Request fields are captured here and held until the beat ends.
            valid_d = 1'b1;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wstrb_d = req_write ? 4'b1111 : 4'b0000;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: rtl/lcd114_fill_master.sv
// Hardware rectangle-fill sequencer: optional boot write, status poll, window setup, pixel burst.
module lcd114_fill_master
    import lcd114_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int          X_OFF    = 40,
    parameter int          Y_OFF    = 53,
    parameter int          TIMEOUT  = 1024,
    parameter int          POLL_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        boot_req,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int             PW        = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [3:0]     CMD_LAST  = 4'(CMD_WORDS - 1);
    localparam logic [15:0]    X_OFF16   = 16'(X_OFF);
    localparam logic [15:0]    Y_OFF16   = 16'(Y_OFF);

    state_t        state_q, state_d;
    logic [7:0]    x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [15:0]   color_q, color_d;
    logic          boot_q, boot_d;
    logic          err_q, err_d, done_q, done_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [16:0]   pix_q, pix_d;

    logic          req, req_write, ack, timeout;
    logic [31:0]   req_addr, req_wdata;
    logic [15:0]   xs, xe, ys, ye;
    logic [8:0]    width, height;
    logic [16:0]   n_pix;
    logic          unused_rdata;

    assign xs     = {8'h00, x0_q} + X_OFF16;
    assign xe     = {8'h00, x1_q} + X_OFF16;
    assign ys     = {8'h00, y0_q} + Y_OFF16;
    assign ye     = {8'h00, y1_q} + Y_OFF16;
    assign width  = {1'b0, x1_q} - {1'b0, x0_q} + 9'd1;
    assign height = {1'b0, y1_q} - {1'b0, y0_q} + 9'd1;
    assign n_pix  = 17'(width) * 17'(height);
    assign unused_rdata = ^mem_rdata[31:1];

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        color_d   = color_q;
        boot_d    = boot_q;
        err_d     = err_q;
        done_d    = 1'b0;
        idx_d     = idx_q;
        poll_d    = poll_q;
        pix_d     = pix_q;
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = BASE + REG_CMD;
        req_wdata = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse belongs to the old run and is dropped.
                if (start && !done_q) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    color_d = color;
                    boot_d  = boot_req;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (x1_q < x0_q || y1_q < y0_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = '0;
                    poll_d  = '0;
                    state_d = boot_q ? ST_BOOT : ST_POLL;
                end
            end
            ST_BOOT: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_addr  = BASE + REG_CTRL;
                req_wdata = BOOT_WORD;
                if (ack) state_d = ST_POLL;
            end
            ST_POLL: begin
                req = 1'b1;
                if (ack) begin
                    if (mem_rdata[0]) begin
                        state_d = ST_CMD;
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        poll_d = poll_q + 1'b1;
                    end
                end
            end
            ST_CMD: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_wdata = cmd_word(idx_q, xs, xe, ys, ye);
                if (ack) begin
                    if (idx_q == CMD_LAST) begin
                        pix_d   = n_pix;
                        state_d = ST_PIX;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PIX: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_addr  = BASE + REG_PIX;
                req_wdata = {16'h0000, color_q};
                if (ack) begin
                    if (pix_q == 17'd1) state_d = ST_FIN;
                    else                pix_d   = pix_q - 17'd1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            boot_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            poll_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            boot_q  <= boot_d;
            err_q   <= err_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            pix_q   <= pix_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

    lcd114_bus_req #(
        .TIMEOUT(TIMEOUT)
    ) u_bus_req (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_write(req_write),
        .ack      (ack),
        .timeout  (timeout),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

endmodule

// File: tb/tb_lcd114_fill_master.sv
// Directed bench for lcd114_fill_master with a logging peripheral model; one line per bus beat.
module tb_lcd114_fill_master;

    logic        clk = 1'b0;
    logic        reset, start, boot_req;
    logic [7:0]  x0, y0, x1, y1;
    logic [15:0] color;
    logic        busy, done, err;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    lcd114_fill_master dut (
        .clk(clk), .reset(reset), .start(start), .boot_req(boot_req),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    localparam int LOGN = 512;
    logic [31:0] log_addr [LOGN];
    logic [31:0] log_wdata[LOGN];
    logic [3:0]  log_wstrb[LOGN];
    int          log_gap  [LOGN];
    int          log_len  [LOGN];

    // Peripheral model state (written by the model) and knobs (written by the tests).
    int nb = 0, cur = 0, nreads = 0, idle_run = 0, wait_cnt = 0;
    int valid_cycles = 0, stab_err = 0, done_total = 0;
    bit in_beat = 1'b0;
    int ready_delay = 2, zero_until = 0, stall_at = -1;

    int checks = 0, errors = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [3:0]  exp_wstrb[$];

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (!in_beat) begin
                    in_beat  = 1'b1;
                    wait_cnt = 0;
                    cur      = nb;
                    if (cur < LOGN) begin
                        log_addr[cur]  = mem_addr;
                        log_wdata[cur] = mem_wdata;
                        log_wstrb[cur] = mem_wstrb;
                        log_gap[cur]   = idle_run;
                        log_len[cur]   = 0;
                    end
                    nb = nb + 1;
                    if (mem_wstrb == 4'b0000) begin
                        mem_rdata = (nreads < zero_until) ? 32'h0 : 32'h1;
                        nreads = nreads + 1;
                    end
                    $display("beat %0d addr=%08h wdata=%08h wstrb=%b", cur, mem_addr, mem_wdata, mem_wstrb);
                end else if (cur < LOGN && (mem_addr !== log_addr[cur] ||
                             mem_wdata !== log_wdata[cur] || mem_wstrb !== log_wstrb[cur])) begin
                    stab_err = stab_err + 1;
                end
                if (cur < LOGN) log_len[cur] = log_len[cur] + 1;
                valid_cycles = valid_cycles + 1;
                idle_run = 0;
                if (cur != stall_at && wait_cnt >= ready_delay) mem_ready = 1'b1;
                wait_cnt = wait_cnt + 1;
            end else begin
                in_beat   = 1'b0;
                mem_ready = 1'b0;
                idle_run  = idle_run + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_total = done_total + 1;
        end
    end

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_addr.push_back(a);
        exp_wdata.push_back(d);
        exp_wstrb.push_back(s);
    endtask

    // Builds the expected beat list from hand-computed panel coordinates.
    task automatic exp_frame(input bit b, input int npoll, input logic [15:0] xs, input logic [15:0] xe,
                             input logic [15:0] ys, input logic [15:0] ye, input int npix,
                             input logic [15:0] c);
        logic [15:0] v[4];
        exp_addr.delete();
        exp_wdata.delete();
        exp_wstrb.delete();
        v[0] = xs; v[1] = xe; v[2] = ys; v[3] = ye;
        if (b) exp_push(32'h8, 32'hFFFF_FFFF, 4'b1111);
        for (int i = 0; i < npoll; i++) exp_push(32'h0, 32'h0, 4'b0000);
        for (int g = 0; g < 2; g++) begin
            exp_push(32'h0, (g == 0) ? 32'h2A : 32'h2B, 4'b1111);
            for (int k = 0; k < 2; k++) begin
                exp_push(32'h0, 32'h100 | {24'h0, v[2*g+k][15:8]}, 4'b1111);
                exp_push(32'h0, 32'h100 | {24'h0, v[2*g+k][7:0]}, 4'b1111);
            end
        end
        exp_push(32'h0, 32'h2C, 4'b1111);
        for (int i = 0; i < npix; i++) exp_push(32'h4, {16'h0, c}, 4'b1111);
    endtask

    // Pulses start for one cycle, then scrambles the inputs to prove they were captured.
    task automatic start_seq(input bit b, input logic [7:0] ax0, input logic [7:0] ay0,
                             input logic [7:0] ax1, input logic [7:0] ay1, input logic [15:0] c);
        @(negedge clk);
        boot_req = b; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        boot_req = ~b; x0 = ~ax0; y0 = ~ay0; x1 = ~ax1; y1 = ~ay1; color = ~c;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; boot_req = 1'b0;
        x0 = 8'h0; y0 = 8'h0; x1 = 8'h0; y1 = 8'h0; color = 16'h0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b err=%b, expected all 0", mem_valid, busy, done, err);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%h, expected 0", mem_addr, mem_wdata, mem_wstrb);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, expected 0 0", busy, mem_valid);
        end
    endtask

    task automatic test_basic;
        int base, d0, lat;
        base = nb; d0 = done_total; ready_delay = 2; zero_until = nreads;
        exp_frame(1'b0, 1, 16'd40, 16'd41, 16'd53, 16'd54, 4, 16'h07E0);
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'h07E0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b, expected 1", busy); end
        wait_done(2000, lat);
        checks++;
        if (lat == 0) begin errors++; $display("FAIL basic_done: no done within 2000 cycles"); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_start_on_done: busy=%b, expected 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_total - d0 != 1) begin errors++; $display("FAIL basic_done_count: %0d, expected 1", done_total - d0); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL basic_err: err=%b, expected 0", err); end
        checks++;
        if (nb - base != exp_addr.size()) begin errors++; $display("FAIL basic_beats: %0d, expected %0d", nb - base, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && base + i < nb; i++) begin
            checks++;
            if (log_addr[base+i] !== exp_addr[i] || log_wstrb[base+i] !== exp_wstrb[i] ||
                (exp_wstrb[i] != 4'b0000 && log_wdata[base+i] !== exp_wdata[i])) begin
                errors++;
                $display("FAIL basic_beat%0d: addr=%h wdata=%h wstrb=%b, expected addr=%h wdata=%h wstrb=%b", i,
                         log_addr[base+i], log_wdata[base+i], log_wstrb[base+i], exp_addr[i], exp_wdata[i], exp_wstrb[i]);
            end
        end
    endtask

    task automatic test_boot;
        int base, lat;
        base = nb; zero_until = nreads;
        exp_frame(1'b1, 1, 16'd42, 16'd44, 16'd63, 16'd63, 3, 16'hF800);
        start_seq(1'b1, 8'd2, 8'd10, 8'd4, 8'd10, 16'hF800);
        wait_done(2000, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (lat == 0 || err !== 1'b0) begin errors++; $display("FAIL boot_done: lat=%0d err=%b, expected done and err 0", lat, err); end
        checks++;
        if (nb - base != exp_addr.size()) begin errors++; $display("FAIL boot_beats: %0d, expected %0d", nb - base, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && base + i < nb; i++) begin
            checks++;
            if (log_addr[base+i] !== exp_addr[i] || log_wstrb[base+i] !== exp_wstrb[i] ||
                (exp_wstrb[i] != 4'b0000 && log_wdata[base+i] !== exp_wdata[i])) begin
                errors++;
                $display("FAIL boot_beat%0d: addr=%h wdata=%h wstrb=%b, expected addr=%h wdata=%h wstrb=%b", i,
                         log_addr[base+i], log_wdata[base+i], log_wstrb[base+i], exp_addr[i], exp_wdata[i], exp_wstrb[i]);
            end
        end
    endtask

    task automatic test_poll;
        int base, d0, lat, reads;
        base = nb; zero_until = nreads + 3;
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'h001F);
        wait_done(2000, lat);
        repeat (2) @(negedge clk);
        reads = 0;
        for (int i = base; i < nb && i < LOGN; i++) if (log_wstrb[i] == 4'b0000) reads++;
        checks++;
        if (reads != 4 || nb - base != 19 || err !== 1'b0) begin
            errors++;
            $display("FAIL poll_retry: reads=%0d beats=%0d err=%b, expected 4 19 0", reads, nb - base, err);
        end
        base = nb; d0 = done_total; zero_until = nreads + 1000;
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'h001F);
        wait_done(2000, lat);
        repeat (3) @(negedge clk);
        zero_until = nreads;
        reads = 0;
        for (int i = base; i < nb && i < LOGN; i++) if (log_wstrb[i] == 4'b0000) reads++;
        checks++;
        if (reads != 64 || nb - base != 64) begin
            errors++;
            $display("FAIL poll_stuck_reads: reads=%0d beats=%0d, expected 64 64", reads, nb - base);
        end
        checks++;
        if (err !== 1'b1 || done_total - d0 != 1) begin
            errors++;
            $display("FAIL poll_stuck_err: err=%b dones=%0d, expected 1 1", err, done_total - d0);
        end
    endtask

    task automatic test_bad_rect;
        int v0, d0, lat;
        v0 = valid_cycles; d0 = done_total;
        start_seq(1'b0, 8'd5, 8'd0, 8'd3, 8'd0, 16'h1111);
        wait_done(10, lat);
        checks++;
        if (lat == 0 || lat > 2) begin errors++; $display("FAIL bad_rect_latency: %0d cycles, expected 1..2", lat); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL bad_rect_err: err=%b, expected 1", err); end
        repeat (5) @(negedge clk);
        checks++;
        if (valid_cycles != v0 || done_total - d0 != 1) begin
            errors++;
            $display("FAIL bad_rect_bus: valid cycles=%0d dones=%0d, expected 0 1", valid_cycles - v0, done_total - d0);
        end
    endtask

    task automatic test_timeout;
        int base, lat;
        base = nb; stall_at = nb + 6; zero_until = nreads;
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'h07E0);
        wait_done(3000, lat);
        repeat (2) @(negedge clk);
        stall_at = -1;
        checks++;
        if (lat == 0 || err !== 1'b1) begin errors++; $display("FAIL timeout_err: lat=%0d err=%b, expected done and err 1", lat, err); end
        checks++;
        if (nb - base != 7 || log_len[base+6] != 1024 || log_wdata[base+6] !== 32'h2B) begin
            errors++;
            $display("FAIL timeout_beat: beats=%0d len=%0d wdata=%h, expected 7 1024 0000002b",
                     nb - base, log_len[base+6], log_wdata[base+6]);
        end
        base = nb;
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'h07E0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: err=%b, expected 0", err); end
        wait_done(2000, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (lat == 0 || err !== 1'b0 || nb - base != 16) begin
            errors++;
            $display("FAIL timeout_recover: lat=%0d err=%b beats=%0d, expected done 0 16", lat, err, nb - base);
        end
    endtask

    task automatic test_reset_mid;
        int base, lat;
        base = nb; zero_until = nreads;
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'hABCD);
        for (int i = 0; i < 500 && nb < base + 14; i++) @(negedge clk);
        checks++;
        if (nb < base + 14) begin errors++; $display("FAIL reset_mid_reach: beats=%0d, expected 14", nb - base); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b busy=%b addr=%h wstrb=%b, expected 0 0 0 0",
                     mem_valid, busy, mem_addr, mem_wstrb);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = nb;
        exp_frame(1'b0, 1, 16'd40, 16'd41, 16'd53, 16'd54, 4, 16'hABCD);
        start_seq(1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 16'hABCD);
        wait_done(2000, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (lat == 0 || err !== 1'b0 || nb - base != exp_addr.size()) begin
            errors++;
            $display("FAIL reset_mid_replay: lat=%0d err=%b beats=%0d, expected done 0 %0d", lat, err, nb - base, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && base + i < nb; i++) begin
            checks++;
            if (log_addr[base+i] !== exp_addr[i] || log_wstrb[base+i] !== exp_wstrb[i] ||
                (exp_wstrb[i] != 4'b0000 && log_wdata[base+i] !== exp_wdata[i])) begin
                errors++;
                $display("FAIL replay_beat%0d: addr=%h wdata=%h wstrb=%b, expected addr=%h wdata=%h wstrb=%b", i,
                         log_addr[base+i], log_wdata[base+i], log_wstrb[base+i], exp_addr[i], exp_wdata[i], exp_wstrb[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int base, lat;
        base = nb; ready_delay = 0; zero_until = nreads;
        exp_frame(1'b0, 1, 16'd50, 16'd51, 16'd73, 16'd73, 2, 16'h1234);
        start_seq(1'b0, 8'd10, 8'd20, 8'd11, 8'd20, 16'h1234);
        wait_done(2000, lat);
        repeat (2) @(negedge clk);
        ready_delay = 2;
        checks++;
        if (lat == 0 || nb - base != exp_addr.size()) begin
            errors++;
            $display("FAIL b2b_beats: lat=%0d beats=%0d, expected done %0d", lat, nb - base, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && base + i < nb; i++) begin
            checks++;
            if (log_addr[base+i] !== exp_addr[i] || log_wstrb[base+i] !== exp_wstrb[i] ||
                (exp_wstrb[i] != 4'b0000 && log_wdata[base+i] !== exp_wdata[i]) ||
                log_len[base+i] != 1 || (i > 0 && log_gap[base+i] != 1)) begin
                errors++;
                $display("FAIL b2b_beat%0d: addr=%h wdata=%h len=%0d gap=%0d, expected addr=%h wdata=%h len=1 gap=1", i,
                         log_addr[base+i], log_wdata[base+i], log_len[base+i], log_gap[base+i], exp_addr[i], exp_wdata[i]);
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bus_stability: %0d unstable cycles, expected 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boot();
        test_poll();
        test_bad_rect();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
